// File: rtl/sprite_pkg.sv
// Shared types and constants for the per-scanline sprite sequencer.
package sprite_pkg;

  localparam int LINE_W = 640;
  localparam int SPR_DIM = 32;
  localparam logic [3:0] TRANSPARENT = 4'h0;

  typedef struct packed {
    logic [5:0] n_sprite;
    logic [9:0] y;
    logic [9:0] x;
  } sprite_attr_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCAN,
    FETCH,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/sprite_attr_table.sv
// Sprite attribute register file: one synchronous write port, one combinational read port.
module sprite_attr_table
  import sprite_pkg::*;
#(
  parameter int N_SPR = 16,
  parameter int AW = $clog2(N_SPR)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  sprite_attr_t  wdata,
  input  logic [AW-1:0] raddr,
  output sprite_attr_t  rdata
);

  sprite_attr_t mem [N_SPR];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N_SPR; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Builds one scanline: clears the line buffer, scans the attribute table, fetches hit
// sprites from the ROM and writes their opaque pixels one cycle after each address.
module sprite_line_scheduler #(
  parameter int N_SPR = 16,
  parameter int LINE_W = 640,
  parameter int SPR_DIM = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [9:0]               line,
  output logic                     busy,
  output logic                     done,
  input  logic                     attr_we,
  input  logic [$clog2(N_SPR)-1:0] attr_addr,
  input  logic [25:0]              attr_wdata,
  output logic [5:0]               spr_n_sprite,
  output logic [9:0]               spr_line,
  output logic [5:0]               spr_pixel,
  input  logic [3:0]               spr_color_code,
  output logic                     lb_we,
  output logic [9:0]               lb_addr,
  output logic [3:0]               lb_wdata
);
  import sprite_pkg::*;

  localparam int AW = $clog2(N_SPR);
  localparam int PW = $clog2(SPR_DIM);

  state_t       state, state_nxt;
  logic [9:0]   line_q;
  logic [9:0]   clr_cnt;
  logic [AW-1:0] ent_cnt;
  logic [PW-1:0] pix_cnt;
  sprite_attr_t rd_attr, cur;
  logic [10:0]  scan_diff;
  logic [9:0]   fetch_row;
  logic         hit, last_ent, last_pix, last_clr;
  logic         wr_vld;
  logic [10:0]  wr_sum;

  sprite_attr_table #(.N_SPR(N_SPR)) u_attr (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (attr_we),
    .waddr  (attr_addr),
    .wdata  (sprite_attr_t'(attr_wdata)),
    .raddr  (ent_cnt),
    .rdata  (rd_attr)
  );

  // 11-bit compare so a y near the bottom of the 10-bit range never wraps into a hit.
  assign scan_diff = {1'b0, line_q} - {1'b0, rd_attr.y};
  assign hit       = (rd_attr.n_sprite != 6'd0) && (line_q >= rd_attr.y) &&
                     (scan_diff < 11'(SPR_DIM));
  assign last_ent  = (ent_cnt == AW'(N_SPR - 1));
  assign last_pix  = (pix_cnt == PW'(SPR_DIM - 1));
  assign last_clr  = (clr_cnt == 10'(LINE_W - 1));
  assign fetch_row = line_q - cur.y;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   if (last_clr) state_nxt = SCAN;
      SCAN:    if (hit) state_nxt = FETCH;
               else if (last_ent) state_nxt = DRAIN;
      FETCH:   if (last_pix) state_nxt = last_ent ? DRAIN : SCAN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    done         = (state == DONE);
    spr_n_sprite = '0;
    spr_line     = '0;
    spr_pixel    = '0;
    lb_we        = 1'b0;
    lb_addr      = '0;
    lb_wdata     = '0;
    if (state == FETCH) begin
      spr_n_sprite = cur.n_sprite;
      spr_line     = fetch_row;
      spr_pixel    = 6'(pix_cnt);
    end
    if (state == CLEAR) begin
      lb_we    = 1'b1;
      lb_addr  = clr_cnt;
      lb_wdata = TRANSPARENT;
    end else if (wr_vld) begin
      lb_we    = (spr_color_code != TRANSPARENT) && (wr_sum < 11'(LINE_W));
      lb_addr  = wr_sum[9:0];
      lb_wdata = spr_color_code;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      line_q  <= '0;
      clr_cnt <= '0;
      ent_cnt <= '0;
      pix_cnt <= '0;
      cur     <= '0;
      wr_vld  <= 1'b0;
      wr_sum  <= '0;
    end else begin
      wr_vld <= (state == FETCH);
      wr_sum <= {1'b0, cur.x} + 11'(pix_cnt);
      case (state)
        IDLE: begin
          if (start) line_q <= line;
          clr_cnt <= '0;
          ent_cnt <= '0;
          pix_cnt <= '0;
        end
        CLEAR: clr_cnt <= clr_cnt + 10'd1;
        SCAN: begin
          cur     <= rd_attr;
          pix_cnt <= '0;
          if (!hit) ent_cnt <= ent_cnt + AW'(1);
        end
        FETCH: begin
          pix_cnt <= pix_cnt + PW'(1);
          if (last_pix) ent_cnt <= ent_cnt + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sprite_line_scheduler.md
# sprite_line_scheduler

- Per-scanline sequencer for the sprite ROM datapath.
- During horizontal blanking of the line before display, it first clears a 640-entry line buffer. It then scans an attribute table of `N_SPR` sprites, drives sprite-select/row/pixel addresses into the sprite ROM block, and writes non-transparent 4-bit color codes into the line buffer.
- Sits between the Avalon register interface (attribute writes), the VGA timing logic (`start`/`line`) and the sprite ROM plus line-buffer BRAM.

## Interface
Parameters:
- `N_SPR`, 16: number of attribute entries (power of 2).
- `LINE_W`, 640: visible pixels per line; also the clear length.
- `SPR_DIM`, 32: sprite width and height in pixels.

Ports:
- `clk` input 1: single clock for all logic.
- `reset_n` input 1: synchronous, active-low reset.
- `start` input 1: pulse requesting that the line given by `line` be built.
- `line` input 10: screen line to build; sampled when `start` is accepted.
- `busy` output 1: high from acceptance of `start` through the DONE state.
- `done` output 1: one-cycle pulse when the line buffer is complete.
- `attr_we` input 1: attribute table write strobe.
- `attr_addr` input log2(N_SPR): entry index to write.
- `attr_wdata` input 26: `{n_sprite[25:20], y[19:10], x[9:0]}`.
- `spr_n_sprite` output 6: sprite select to the ROM block.
- `spr_line` output 10: row within the sprite, 0..31.
- `spr_pixel` output 6: column within the sprite, 0..31.
- `spr_color_code` input 4: ROM data; valid one cycle after address.
- `lb_we` output 1: line buffer write enable.
- `lb_addr` output 10: line buffer address.
- `lb_wdata` output 4: color code to write.

## Operation
- Attribute table: `N_SPR` registers; `n_sprite == 0` means the entry is disabled. Writes take effect at the next clock edge and are accepted in any state.
- States:
  - IDLE: accept `start` (latch `line`) -> CLEAR.
  - CLEAR: write 0 to `lb_addr` 0..`LINE_W-1`, one per cycle -> SCAN with entry 0.
  - SCAN: one cycle per entry. Latch the entry.
    - hit = `n_sprite != 0` && `line >= y` && `(line - y) < SPR_DIM`, compared at 11 bits with no wrap.
    - hit -> FETCH. Miss -> next entry. Miss on the last entry -> DRAIN.
  - FETCH: 32 cycles. Drive `spr_pixel` = 0..31, `spr_line = line - y`, `spr_n_sprite` from the latched entry. After pixel 31 -> SCAN next entry, or DRAIN if this was the last entry.
  - DRAIN: one cycle, to retire the final ROM read -> DONE.
  - DONE: assert `done` -> IDLE.
- Write stage (one cycle after each FETCH address):
  - `lb_we = (spr_color_code != 0) && (x + pixel < LINE_W)`, computed as an 11-bit sum.
  - `lb_addr = x + pixel`; `lb_wdata = spr_color_code`.
  - Color code 0 is transparent and is never written.
  - Pixels past column `LINE_W-1` are dropped; there is no wrap to column 0.
- Priority: entries are drawn in ascending index, so the higher index overwrites and appears on top.
- Outside FETCH, `spr_*` outputs hold 0. Outside CLEAR and the write stage, `lb_we` = 0.

## Timing
- Reset values:
  - state IDLE; `busy`, `done`, `lb_we` = 0.
  - `lb_addr`, `lb_wdata`, `spr_*` = 0.
  - All attribute entries = 0, i.e. disabled.
- `start` is accepted in IDLE only. `start` while `busy` is ignored and is not queued.
- Relative to the accepting edge at cycle 0:
  - CLEAR occupies cycles 1..`LINE_W`.
  - SCAN of entry 0 is at `LINE_W+1`.
- Total latency to `done` = `LINE_W` + `N_SPR` + 32·hits + 2 cycles. Defaults with 0 hits: `done` at cycle 658; with 1 hit: 690.
- The ROM read latency is exactly 1 cycle; the write for pixel p occurs at FETCH cycle p+1.
- Attribute write in the same cycle as the SCAN of that entry: SCAN uses the old value. The latched entry is immune to later writes during its FETCH.
- `reset_n` low mid-line: next edge returns to IDLE. No further `lb_we`, no `done`, and the attribute table is cleared.
- Worst case at defaults, 16 hits: 1170 cycles, which fits within one 1600-clk line at 50 MHz.

## Structure
- Package `sprite_pkg` holds:
  - `sprite_attr_t` struct `{n_sprite, y, x}`.
  - state enum `{IDLE, CLEAR, SCAN, FETCH, DRAIN, DONE}`.
  - constants `LINE_W`, `SPR_DIM`, `TRANSPARENT = 4'h0`.
- Sub-module `sprite_attr_table`: register file with one write port and one combinational read port indexed by the scan counter.
- The top level holds the FSM, the entry/pixel/clear counters, and the single-stage write pipeline.

## Test plan
- No sprites enabled; `start` with `line` = 100 -> 640 writes of 0 to addresses 0..639, then no further writes, `done` at cycle 658, `busy` low after it.
- Entry 3 = {n = 1, y = 90, x = 200}; `line` = 100 -> `spr_line` = 10, `spr_n_sprite` = 1, 32 addresses issued. Non-zero ROM codes are written to 200..231 one cycle after each address. `done` at cycle 690.
- Entry at x = 620 -> only addresses 620..639 are written; pixels 20..31 are suppressed.
- Entries 0 and 5 overlap at the same x -> entry 5 codes occupy the overlap. Pixels where entry 5 has code 0 keep entry 0's value.
- y = 100 with `line` = 131 -> hit, row 31. With `line` = 132 or `line` = 99 -> miss and no fetch. y = 1000 with `line` = 5 -> miss, with no 10-bit wrap.
- `start` pulsed while busy is ignored. `reset_n` low at cycle 300 -> `lb_we` = 0 from the next cycle, no `done`, and a subsequent `start` behaves like the first scenario.
